// File: rtl/morse_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : morse_key_sequencer
// Brief    : Times a raw Morse key line and emits one-hot dot/dash/char/word
//            pulses that respect the downstream detector's idle windows.
// Revision : 1.0
// ============================================================================
module morse_key_sequencer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned MAX_UNITS   = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic key_in,
  input  logic err_clr,
  output logic dot_inp,
  output logic dash_inp,
  output logic char_space_inp,
  output logic word_space_inp,
  output logic busy,
  output logic overrun_err,
  output logic stuck_err
);

  localparam int unsigned C_DASH_MIN  = 2 * UNIT_CYCLES;
  localparam int unsigned C_STUCK_LIM = MAX_UNITS * UNIT_CYCLES;
  localparam int unsigned C_CHAR_AT   = 3 * UNIT_CYCLES - 1;
  localparam int unsigned C_WORD_AT   = 7 * UNIT_CYCLES - 1;
  localparam int unsigned MARK_W      = $clog2(C_STUCK_LIM + 1);
  localparam int unsigned GAP_W       = $clog2(C_WORD_AT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               key_meta_q, key_s_q;
  logic [MARK_W-1:0]  mark_cnt_q, mark_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [2:0]         guard_q, guard_d;
  logic               pend_valid_q, pend_valid_d;
  logic               pend_dash_q, pend_dash_d;
  logic               dot_q, dot_d, dash_q, dash_d;
  logic               char_q, char_d, word_q, word_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d, stuck_q, stuck_d;

  logic               w_classify;
  logic               w_cls_dash;
  logic               w_guard_clear;
  logic               w_overrun_set;
  logic               w_stuck_set;

  assign w_cls_dash    = (mark_cnt_q >= MARK_W'(C_DASH_MIN));
  assign w_guard_clear = (guard_q == 3'd0);

  always_comb begin
    state_d       = state_q;
    mark_cnt_d    = mark_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    guard_d       = w_guard_clear ? 3'd0 : guard_q - 3'd1;
    pend_valid_d  = pend_valid_q;
    pend_dash_d   = pend_dash_q;
    dot_d         = 1'b0;
    dash_d        = 1'b0;
    char_d        = 1'b0;
    word_d        = 1'b0;
    w_classify    = 1'b0;
    w_overrun_set = 1'b0;
    w_stuck_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_s_q) begin
          state_d    = S_MARK;
          mark_cnt_d = MARK_W'(1);
        end
      end
      S_MARK: begin
        if (key_s_q) begin
          mark_cnt_d = mark_cnt_q + MARK_W'(1);
          if (mark_cnt_q == MARK_W'(C_STUCK_LIM - 1)) begin
            state_d     = S_STUCK;
            w_stuck_set = 1'b1;
          end
        end else begin
          w_classify = 1'b1;
          state_d    = S_SPACE;
        end
      end
      S_SPACE: begin
        if (key_s_q) begin
          state_d    = S_MARK;
          mark_cnt_d = MARK_W'(1);
        end else if (!pend_valid_q) begin
          // Gap timing is frozen until the pending symbol has actually gone out.
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (gap_cnt_q == GAP_W'(C_CHAR_AT)) begin
            char_d  = 1'b1;
            guard_d = 3'd3;
          end else if (gap_cnt_q == GAP_W'(C_WORD_AT)) begin
            word_d  = 1'b1;
            guard_d = 3'd7;
            state_d = S_IDLE;
          end
        end
      end
      S_STUCK: begin
        if (!key_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pend_valid_q && w_guard_clear) begin
      dot_d        = ~pend_dash_q;
      dash_d       = pend_dash_q;
      gap_cnt_d    = '0;
      pend_valid_d = w_classify;
      if (w_classify) pend_dash_d = w_cls_dash;
    end else if (w_classify) begin
      if (w_guard_clear) begin
        dot_d     = ~w_cls_dash;
        dash_d    = w_cls_dash;
        gap_cnt_d = '0;
      end else if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_dash_d  = w_cls_dash;
      end else begin
        w_overrun_set = 1'b1;
      end
    end

    if (!en) begin
      state_d       = S_IDLE;
      mark_cnt_d    = '0;
      gap_cnt_d     = '0;
      guard_d       = 3'd0;
      pend_valid_d  = 1'b0;
      pend_dash_d   = 1'b0;
      dot_d         = 1'b0;
      dash_d        = 1'b0;
      char_d        = 1'b0;
      word_d        = 1'b0;
      w_overrun_set = 1'b0;
      w_stuck_set   = 1'b0;
    end

    busy_d    = (state_d != S_IDLE) || pend_valid_d;
    overrun_d = w_overrun_set | (overrun_q & ~err_clr);
    stuck_d   = w_stuck_set | (stuck_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      key_meta_q   <= 1'b0;
      key_s_q      <= 1'b0;
      mark_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      guard_q      <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_dash_q  <= 1'b0;
      dot_q        <= 1'b0;
      dash_q       <= 1'b0;
      char_q       <= 1'b0;
      word_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_meta_q   <= key_in;
      key_s_q      <= key_meta_q;
      mark_cnt_q   <= mark_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      guard_q      <= guard_d;
      pend_valid_q <= pend_valid_d;
      pend_dash_q  <= pend_dash_d;
      dot_q        <= dot_d;
      dash_q       <= dash_d;
      char_q       <= char_d;
      word_q       <= word_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      stuck_q      <= stuck_d;
    end
  end

  assign dot_inp        = dot_q;
  assign dash_inp       = dash_q;
  assign char_space_inp = char_q;
  assign word_space_inp = word_q;
  assign busy           = busy_q;
  assign overrun_err    = overrun_q;
  assign stuck_err      = stuck_q;

endmodule
`default_nettype wire
